// File: rtl/xvga_timing.sv
// XVGA raster timing generator (1024x768 @ 60 Hz on a 65 MHz pixel clock).
// Produces pixel/line counters, active-low syncs, blanking, line and frame
// strobes and a completed-frame counter. Every output is registered and is
// decoded from the next counter values so all of them line up with the
// hcount/vcount presented in the same cycle.
module xvga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FRONT  = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BACK   = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 29
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);

  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        blank_nxt;
  logic        line_nxt;
  logic        frame_nxt;

  // Next raster position and the signals decoded from it; with enable low
  // the position holds, so the decodes hold too and only the strobes drop.
  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (enable) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        h_nxt = hcount + 11'd1;
      end
    end
    hsync_nxt = !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
    vsync_nxt = !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
    blank_nxt = (h_nxt >= H_VIS) || (v_nxt >= V_VIS);
    line_nxt  = enable && (h_nxt == '0);
    frame_nxt = line_nxt && (v_nxt == '0);
  end

  // Output registers; the frame counter advances on the edge that raises frame_start.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      blank       <= blank_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
      if (frame_nxt) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: one instance at full XVGA timing for line-level
// behaviour, one with a tiny raster (16 x 11) so whole frames, vsync and
// frame counter wrap fit in a short run. Stimulus pushes expected outputs
// into a queue; a monitor pops one entry per sample point and compares.
module tb_xvga_timing;

  localparam int HA [2] = '{1024, 8};
  localparam int HF [2] = '{24, 2};
  localparam int HS [2] = '{136, 3};
  localparam int HB [2] = '{160, 3};
  localparam int VA [2] = '{768, 6};
  localparam int VF [2] = '{3, 1};
  localparam int VS [2] = '{6, 2};
  localparam int VB [2] = '{29, 2};

  logic vclock = 1'b0;
  always #5 vclock = ~vclock;

  logic        reset_n_b, enable_b;
  logic [10:0] hcount_b;
  logic [9:0]  vcount_b;
  logic        hsync_b, vsync_b, blank_b, line_start_b, frame_start_b;
  logic [15:0] frame_count_b;

  logic        reset_n_s, enable_s;
  logic [10:0] hcount_s;
  logic [9:0]  vcount_s;
  logic        hsync_s, vsync_s, blank_s, line_start_s, frame_start_s;
  logic [15:0] frame_count_s;

  xvga_timing dut_b (
    .vclock(vclock), .reset_n(reset_n_b), .enable(enable_b),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .blank(blank_b), .line_start(line_start_b), .frame_start(frame_start_b),
    .frame_count(frame_count_b)
  );

  xvga_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .vclock(vclock), .reset_n(reset_n_s), .enable(enable_s),
    .hcount(hcount_s), .vcount(vcount_s), .hsync(hsync_s), .vsync(vsync_s),
    .blank(blank_s), .line_start(line_start_s), .frame_start(frame_start_s),
    .frame_count(frame_count_s)
  );

  typedef struct {
    int    sel;
    string name;
    int    h;
    int    v;
    bit    hs;
    bit    vs;
    bit    bl;
    bit    ls;
    bit    fs;
    int    fc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  event sample_ev;

  // Reference raster position and strobes per instance.
  int mh [2];
  int mv [2];
  int mfc [2];
  bit mls [2];
  bit mfs [2];

  function automatic void model_reset(int s);
    mh[s] = 0; mv[s] = 0; mfc[s] = 0; mls[s] = 0; mfs[s] = 0;
  endfunction

  function automatic void step(int s, bit en);
    int ht, vt;
    ht = HA[s] + HF[s] + HS[s] + HB[s];
    vt = VA[s] + VF[s] + VS[s] + VB[s];
    if (en) begin
      if (mh[s] == ht - 1) begin
        mh[s] = 0;
        mv[s] = (mv[s] == vt - 1) ? 0 : mv[s] + 1;
      end else begin
        mh[s] = mh[s] + 1;
      end
      mls[s] = (mh[s] == 0);
      mfs[s] = (mh[s] == 0) && (mv[s] == 0);
      if (mfs[s]) mfc[s] = (mfc[s] + 1) % 65536;
    end else begin
      mls[s] = 0;
      mfs[s] = 0;
    end
  endfunction

  function automatic void push(int s, string nm);
    exp_t e;
    e.sel  = s;
    e.name = nm;
    e.h    = mh[s];
    e.v    = mv[s];
    e.hs   = !((mh[s] >= HA[s] + HF[s]) && (mh[s] < HA[s] + HF[s] + HS[s]));
    e.vs   = !((mv[s] >= VA[s] + VF[s]) && (mv[s] < VA[s] + VF[s] + VS[s]));
    e.bl   = (mh[s] >= HA[s]) || (mv[s] >= VA[s]);
    e.ls   = mls[s];
    e.fs   = mfs[s];
    e.fc   = mfc[s];
    sbq.push_back(e);
  endfunction

  // One clock of stimulus for instance s; the other instance is held.
  task automatic tick(int s, bit en, string nm, bit chk);
    @(negedge vclock);
    if (s == 0) begin
      enable_b = en; enable_s = 1'b0;
    end else begin
      enable_s = en; enable_b = 1'b0;
    end
    step(s, en);
    step(1 - s, 1'b0);
    if (chk) push(s, nm);
  endtask

  task automatic run(int s, int n, string nm, bit chk);
    for (int i = 0; i < n; i++) tick(s, 1'b1, nm, chk);
  endtask

  // Reset asserted between edges; outputs are checked before the next edge.
  task automatic do_reset(int s, string nm);
    @(negedge vclock);
    enable_b = 1'b0;
    enable_s = 1'b0;
    step(0, 1'b0);
    step(1, 1'b0);
    #2;
    if (s == 0) reset_n_b = 1'b0;
    else        reset_n_s = 1'b0;
    model_reset(s);
    push(s, nm);
    -> sample_ev;
    @(negedge vclock);
    if (s == 0) reset_n_b = 1'b1;
    else        reset_n_s = 1'b1;
  endtask

  // Monitor: pops one expectation per sample point and compares.
  initial begin
    exp_t e;
    int ah, av, afc;
    bit ahs, avs, abl, als, afs;
    forever begin
      @(posedge vclock or sample_ev);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.sel == 0) begin
          ah = hcount_b; av = vcount_b; ahs = hsync_b; avs = vsync_b; abl = blank_b;
          als = line_start_b; afs = frame_start_b; afc = frame_count_b;
        end else begin
          ah = hcount_s; av = vcount_s; ahs = hsync_s; avs = vsync_s; abl = blank_s;
          als = line_start_s; afs = frame_start_s; afc = frame_count_s;
        end
        checks++;
        if (ah != e.h || av != e.v || ahs != e.hs || avs != e.vs || abl != e.bl ||
            als != e.ls || afs != e.fs || afc != e.fc) begin
          errors++;
          $display("FAIL %s[%0d] @%0t: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d",
                   e.name, e.sel, $time, ah, av, ahs, avs, abl, als, afs, afc,
                   e.h, e.v, e.hs, e.vs, e.bl, e.ls, e.fs, e.fc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n_b = 1'b0; enable_b = 1'b0;
    reset_n_s = 1'b0; enable_s = 1'b0;
    model_reset(0);
    model_reset(1);

    // Full-size raster: reset, one full line, hold inside hsync, mid-sync reset.
    do_reset(0, "reset_b");
    run(0, 1344, "line_b", 1'b1);
    run(0, 1100, "to_1100_b", 1'b1);
    for (int i = 0; i < 50; i++) tick(0, 1'b0, "hold_b", 1'b1);
    tick(0, 1'b1, "reenable_b", 1'b1);
    run(0, 49, "to_1150_b", 1'b1);
    do_reset(0, "midsync_reset_b");
    run(0, 5, "restart_b", 1'b1);

    // Small raster: two full frames, strobe drop on enable, mid-vsync reset.
    do_reset(1, "reset_s");
    run(1, 2 * 176, "frames_s", 1'b1);
    tick(1, 1'b0, "strobe_drop_s", 1'b1);
    for (int i = 0; i < 5; i++) tick(1, 1'b0, "hold_s", 1'b1);
    run(1, 141, "to_vsync_s", 1'b1);
    do_reset(1, "midvsync_reset_s");
    run(1, 20, "restart_s", 1'b1);

    // Frame counter wrap: preload 65535, finish the frame.
    tick(1, 1'b1, "pre_force_s", 1'b0);
    force dut_s.frame_count = 16'hFFFF;
    #1;
    release dut_s.frame_count;
    mfc[1] = 65535;
    run(1, 160, "fc_wrap_s", 1'b1);

    @(negedge vclock);
    @(negedge vclock);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unchecked entries, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
